rect_fill: RTL and testbench

RECT_FILL -- requirements
Module: rect_fill

---
 rtl/rect_fill.sv | 159 +++++++++++++++
 tb/tb_rect_fill.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill.sv
// rect_fill: fills an axis-aligned rectangle of a frame buffer with one colour,
// writing one pixel per clock in raster order. Every output is a flop.
// Optional clipping to the W x H screen is enabled by defining RECT_FILL_CLIP_EN;
// without it the rectangle is used as given and addresses wrap modulo 2**ADDR_W.
module rect_fill #(
    parameter int W      = 320,
    parameter int H      = 240,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              fb_en,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(W);

    state_t              r_state;
    state_t              w_next;

    logic [9:0]          w_w_eff;
    logic [8:0]          w_h_eff;
    logic                w_accept;
    logic                w_zero;
    logic                w_last;
    logic [ADDR_W-1:0]   w_start;

    logic [9:0]          r_col;
    logic [9:0]          r_w_last;
    logic [8:0]          r_row;
    logic [8:0]          r_h_last;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [DATA_W-1:0]   r_fb_din;
    logic                r_fb_en;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;

    // Row offset y*W as a shift-add over the bits of y against the constant W,
    // so the start address needs no general multiplier.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc + ADDR_W'(W << i);
        end
        return acc;
    endfunction

`ifdef RECT_FILL_CLIP_EN
    // Clip the offered rectangle to the visible screen.
    always_comb begin
        w_w_eff = '0;
        w_h_eff = '0;
        if ((int'(cmd_x) < W) && (int'(cmd_y) < H)) begin
            w_w_eff = (int'(cmd_w) < (W - int'(cmd_x))) ? cmd_w : 10'(W - int'(cmd_x));
            w_h_eff = (int'(cmd_h) < (H - int'(cmd_y))) ? cmd_h : 9'(H - int'(cmd_y));
        end
    end
`else
    // Unclipped: off-screen pixels simply wrap in the address space.
    always_comb begin
        w_w_eff = cmd_w;
        w_h_eff = cmd_h;
    end
`endif

    assign w_accept = (r_state == IDLE) && cmd_valid;
    assign w_zero   = (w_w_eff == 10'd0) || (w_h_eff == 9'd0);
    assign w_last   = (r_col == r_w_last) && (r_row == r_h_last);
    assign w_start  = row_offset(cmd_y) + ADDR_W'(cmd_x);

    // State register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; the pixel on the outputs during FILL is the one indexed by r_col/r_row.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next = w_zero ? DONE : FILL;
            FILL:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fb_en     <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
            r_fb_en     <= (w_next == FILL);
        end
    end

    // Pixel walker: latch the command on accept, then step +1 per pixel and +W per row.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_addr  <= '0;
            r_fb_din   <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_w_last   <= '0;
            r_h_last   <= '0;
        end else if (w_accept) begin
            r_fb_addr  <= w_start;
            r_row_base <= w_start;
            r_fb_din   <= cmd_color;
            r_col      <= '0;
            r_row      <= '0;
            r_w_last   <= w_w_eff - 10'd1;
            r_h_last   <= w_h_eff - 9'd1;
        end else if ((r_state == FILL) && !w_last) begin
            if (r_col == r_w_last) begin
                r_col      <= '0;
                r_row      <= r_row + 9'd1;
                r_row_base <= r_row_base + W_ADDR;
                r_fb_addr  <= r_row_base + W_ADDR;
            end else begin
                r_col      <= r_col + 10'd1;
                r_fb_addr  <= r_fb_addr + ADDR_W'(1);
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fb_en     = r_fb_en;
    assign fb_we     = r_fb_en;
    assign fb_addr   = r_fb_addr;
    assign fb_din    = r_fb_din;

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboard bench for rect_fill: the driver pushes expected writes and done
// events (with the cycle they must appear in) when a command is accepted;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rect_fill;

    localparam int W      = 320;
    localparam int H      = 240;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 17;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int cyc;
        int span;
    } dn_t;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [8:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              fb_en;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_din;
    logic              busy;
    logic              done;

    wr_t wq[$];
    dn_t dq[$];
    int  n_vec  = 0;
    int  n_err  = 0;
    int  cyc    = 0;
    int  busy_run = 0;
    int  n_writes = 0;
    int  acc1, acc2, wr_base;

    rect_fill #(.W(W), .H(H), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .fb_en    (fb_en),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_din   (fb_din),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: expected writes and done event for a command accepted at cycle acc.
    task automatic model(input int x, input int y, input int w, input int h,
                         input int c, input int acc);
        int k;
        int ew, eh;
        ew = w;
        eh = h;
`ifdef RECT_FILL_CLIP_EN
        if (x >= W || y >= H) begin
            ew = 0;
            eh = 0;
        end else begin
            if (ew > W - x) ew = W - x;
            if (eh > H - y) eh = H - y;
        end
`endif
        k = 0;
        for (int r = 0; r < eh; r++) begin
            for (int col = 0; col < ew; col++) begin
                wr_t e;
                e.addr = ((y + r) * W + x + col) % (1 << ADDR_W);
                e.data = c;
                e.cyc  = acc + k;
                wq.push_back(e);
                k++;
            end
        end
        begin
            dn_t d;
            d.cyc  = (k == 0) ? acc : acc + k;
            d.span = k + 1;
            dq.push_back(d);
        end
    endtask

    // Offer a command, wait (bounded) for acceptance, record the model.
    task automatic send(input int x, input int y, input int w, input int h,
                        input int c, input bit hold, output int acc);
        int guard;
        @(negedge clk_sys);
        cmd_valid = 1'b1;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = DATA_W'(c);
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", 0, 1);
        acc = cyc + 1;
        model(x, y, w, h, c, acc);
        @(posedge clk_sys);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((wq.size() != 0 || dq.size() != 0) && guard < 2000) begin
            @(negedge clk_sys);
            guard++;
        end
        chk("drain_timeout", (guard < 2000) ? 1 : 0, 1);
        repeat (2) @(negedge clk_sys);
    endtask

    // Monitor: compare every write and done pulse against the scoreboard.
    always @(negedge clk_sys) begin
        if (rst_n === 1'b1) begin
            if (busy) busy_run++;
            if (fb_en || fb_we) begin
                n_writes++;
                chk("en_eq_we", int'(fb_en), int'(fb_we));
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", int'(fb_addr), e.addr);
                    chk("wr_data", int'(fb_din), e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("busy_span", busy_run, d.span);
                    chk("done_ready", int'(cmd_ready), 0);
                    chk("done_writes_left", wq.size(), 0);
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_en",    int'(fb_en), 0);
        chk("rst_we",    int'(fb_we), 0);
        chk("rst_addr",  int'(fb_addr), 0);
        chk("rst_din",   int'(fb_din), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // 4x2 at origin
        send(0, 0, 4, 2, 16'hF800, 1'b0, acc1);
        drain();

        // zero width
        send(5, 10, 0, 7, 16'h1234, 1'b0, acc1);
        drain();

        // interior rectangle and a single column
        send(10, 20, 3, 3, 16'h07E0, 1'b0, acc1);
        drain();
        send(100, 50, 1, 3, 16'hABCD, 1'b0, acc1);
        drain();

        // back-to-back 1x1 with cmd_valid held high
        wr_base = n_writes;
        send(7, 7, 1, 1, 16'h001F, 1'b1, acc1);
        send(7, 7, 1, 1, 16'h001F, 1'b0, acc2);
        chk("b2b_accept_gap", acc2 - acc1, 3);
        drain();
        chk("b2b_writes", n_writes - wr_base, 2);

        // bottom-right corner: clipped or wrapping depending on build
        send(318, 239, 5, 3, 16'h5555, 1'b0, acc1);
        drain();

        // asynchronous reset on the third write of a 10x1 fill
        send(0, 0, 10, 1, 16'hFFFF, 1'b0, acc1);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we", int'(fb_we), 0);
        chk("abort_en", int'(fb_en), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        wq.delete();
        dq.delete();
        busy_run = 0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_idle_busy", int'(busy), 0);

        // a normal command still works after the abort
        send(2, 3, 2, 2, 16'h0F0F, 1'b0, acc1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
